video_control_arbiter: RTL and testbench

- Arbitrates register-write requests from several masters onto the single level-sampled control_op/control_data bus of the video formatter. Typical masters: the CPU register bridge, the palette bulk loader and the sprite uploader.
- Each operation is held stable for a fixed number of cycles so the formatter's two-flop input synchronizer captures it, then separated from the next operation by idle (op 0) cycles.
- Mode-changing operations can be deferred until vertical blank so timing and format changes never tear a visible frame.

---
 rtl/video_control_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_video_control_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_control_arbiter.sv
// video_control_arbiter
// Arbitrates register-write requests from several masters onto the formatter's
// level-sampled control_op/control_data bus. Each accepted op is held for
// HOLD_CYCLES cycles, then followed by GAP_CYCLES cycles of op 0. Mode-changing
// ops can optionally be deferred until a synchronised vertical blank.
//
// Ports:
//   m_axis_vid_aclk  clock
//   aresetn          synchronous active-low reset
//   req_valid/ready  per-requester handshake (ready is combinational)
//   req_op/req_data  per-requester op (8b) and data (32b) slices
//   req_lock         keep the grant on this requester after its transfer
//   defer_en         defer mode ops until vblank
//   control_vblank   asynchronous vblank flag from the formatter
//   control_op/data  registered op/data to the formatter
//   busy             high whenever not idle
//   grant_idx        index of the last accepted requester
//   ops_issued       wrapping count of ops driven
module video_control_arbiter #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                   m_axis_vid_aclk,
  input  logic                   aresetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [8*N_REQ-1:0]     req_op,
  input  logic [32*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic                   defer_en,
  input  logic                   control_vblank,
  output logic [7:0]             control_op,
  output logic [31:0]            control_data,
  output logic                   busy,
  output logic [1:0]             grant_idx,
  output logic [15:0]            ops_issued
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_VBL = 2'd1,
    S_HOLD     = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         op_q, op_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         ctl_op_d;
  logic [31:0]        ctl_data_d;
  logic [1:0]         grant_d;
  logic [15:0]        ops_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic               vbl_ff1, vbl_s;

  logic [N_REQ-1:0]   eligible;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               accept;
  logic               start_hold;
  logic [7:0]         sel_op;
  logic [31:0]        sel_data;

  // Ops that change timing/format and may wait for vblank
  function automatic logic is_mode_op(input logic [7:0] op);
    case (op)
      8'd1, 8'd2, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10: is_mode_op = 1'b1;
      default:                                    is_mode_op = 1'b0;
    endcase
  endfunction

  // Round-robin search from rr_q; a lock owner masks everyone else
  always_comb begin
    eligible  = req_valid;
    if (lock_vld_q) begin
      eligible = req_valid & (N_REQ'(1) << lock_idx_q);
    end
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % N_REQ);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Combinational accept for the granted requester while idle
  always_comb begin
    req_ready = '0;
    if (aresetn && (state_q == S_IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept   = aresetn && (state_q == S_IDLE) && gnt_found;
  assign sel_op   = req_op[32'(gnt_idx) * 8 +: 8];
  assign sel_data = req_data[32'(gnt_idx) * 32 +: 32];

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    data_d     = data_q;
    ctl_op_d   = control_op;
    ctl_data_d = control_data;
    grant_d    = grant_idx;
    ops_d      = ops_issued;
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    start_hold = 1'b0;

    case (state_q)
      S_IDLE: begin
        ctl_op_d = '0;
        if (accept) begin
          op_d       = sel_op;
          data_d     = sel_data;
          grant_d    = 2'(gnt_idx);
          rr_d       = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
          lock_vld_d = req_lock[gnt_idx];
          lock_idx_d = gnt_idx;
          if (defer_en && is_mode_op(sel_op)) begin
            state_d = S_WAIT_VBL;
          end else begin
            start_hold = 1'b1;
          end
        end
      end
      S_WAIT_VBL: begin
        ctl_op_d = '0;
        if (vbl_s || !defer_en) begin
          start_hold = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          ctl_op_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        ctl_op_d = '0;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        ctl_op_d = '0;
      end
    endcase

    // HOLD entry drives the latched pair and counts the op
    if (start_hold) begin
      state_d    = S_HOLD;
      cnt_d      = HOLD_LAST;
      ctl_op_d   = op_d;
      ctl_data_d = data_d;
      ops_d      = ops_issued + 16'd1;
    end
  end

  // State and output registers; vblank crosses via a 2-flop synchronizer
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      data_q       <= '0;
      control_op   <= '0;
      control_data <= '0;
      busy         <= 1'b0;
      grant_idx    <= '0;
      ops_issued   <= '0;
      rr_q         <= '0;
      lock_vld_q   <= 1'b0;
      lock_idx_q   <= '0;
      vbl_ff1      <= 1'b0;
      vbl_s        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      data_q       <= data_d;
      control_op   <= ctl_op_d;
      control_data <= ctl_data_d;
      busy         <= (state_d != S_IDLE);
      grant_idx    <= grant_d;
      ops_issued   <= ops_d;
      rr_q         <= rr_d;
      lock_vld_q   <= lock_vld_d;
      lock_idx_q   <= lock_idx_d;
      vbl_ff1      <= control_vblank;
      vbl_s        <= vbl_ff1;
    end
  end

endmodule

// File: tb/tb_video_control_arbiter.sv
// Bench for video_control_arbiter: timeline model checked every cycle plus
// directed literal expectations.
module tb_video_control_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned H = 4;
  localparam int unsigned G = 2;

  logic            clk;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [8*N-1:0]  req_op;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_lock;
  logic            defer_en;
  logic            control_vblank;
  logic [7:0]      control_op;
  logic [31:0]     control_data;
  logic            busy;
  logic [1:0]      grant_idx;
  logic [15:0]     ops_issued;

  video_control_arbiter #(.N_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .m_axis_vid_aclk (clk),
    .aresetn         (aresetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_data        (req_data),
    .req_lock        (req_lock),
    .defer_en        (defer_en),
    .control_vblank  (control_vblank),
    .control_op      (control_op),
    .control_data    (control_data),
    .busy            (busy),
    .grant_idx       (grant_idx),
    .ops_issued      (ops_issued)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- timeline model ----------------
  bit          mv      = 0;
  int          cyc     = 0;
  int          idle_at = 0;
  int          hold_s  = -10;
  int          hold_e  = -10;
  bit          pend    = 0;
  int          rr      = 0;
  bit          lk      = 0;
  int          lk_idx  = 0;
  bit          v1      = 0;
  bit          v2      = 0;
  logic [7:0]  m_op    = '0;
  logic [31:0] m_data  = '0;
  logic [7:0]  e_op    = '0;
  logic [31:0] e_data  = '0;
  logic        e_busy  = 0;
  logic [1:0]  e_grant = '0;
  logic [15:0] e_ops   = '0;

  function automatic bit is_mode(input logic [7:0] op);
    return (op == 8'd1) || (op == 8'd2) || (op == 8'd4) || (op == 8'd6) ||
           (op == 8'd7) || (op == 8'd8) || (op == 8'd10);
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    int c;
    model_grant = -1;
    for (int i = 0; i < int'(N); i++) begin
      c = (rr + i) % int'(N);
      if (model_grant < 0 && v[c] && (!lk || c == lk_idx)) model_grant = c;
    end
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] er;
    int  g;
    bit  idle;
    bit  sched;
    idle  = !pend && (cyc >= idle_at);
    g     = model_grant(req_valid);
    er    = '0;
    if (aresetn && idle && g >= 0) er[g] = 1'b1;
    if (mv) begin
      check("m_ready", 32'(req_ready), 32'(er));
      check("m_op", 32'(control_op), 32'(e_op));
      check("m_data", control_data, e_data);
      check("m_busy", 32'(busy), 32'(e_busy));
      check("m_grant", 32'(grant_idx), 32'(e_grant));
      check("m_ops", 32'(ops_issued), 32'(e_ops));
    end
    // advance to the cycle after the coming edge
    sched = 0;
    if (!aresetn) begin
      rr = 0; lk = 0; lk_idx = 0; pend = 0; idle_at = cyc + 1;
      hold_s = -10; hold_e = -10; v1 = 0; v2 = 0;
      e_op = '0; e_data = '0; e_busy = 0; e_grant = '0; e_ops = '0;
      mv = 1;
      cyc++;
    end else begin
      if (idle && g >= 0) begin
        m_op    = req_op[8*g +: 8];
        m_data  = req_data[32*g +: 32];
        e_grant = 2'(g);
        rr      = (g + 1) % int'(N);
        lk      = req_lock[g];
        lk_idx  = g;
        if (defer_en && is_mode(m_op)) pend = 1;
        else sched = 1;
      end else if (pend && (v2 || !defer_en)) begin
        pend  = 0;
        sched = 1;
      end
      if (sched) begin
        hold_s  = cyc + 1;
        hold_e  = cyc + int'(H);
        idle_at = cyc + 1 + int'(H) + int'(G);
        e_ops   = e_ops + 16'd1;
      end
      v2 = v1;
      v1 = control_vblank;
      cyc++;
      e_op = (cyc >= hold_s && cyc <= hold_e) ? m_op : 8'd0;
      if (cyc == hold_s) e_data = m_data;
      e_busy = pend || (cyc < idle_at);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_req(input int i, input logic [7:0] op, input logic [31:0] data);
    req_op[8*i +: 8]    = op;
    req_data[32*i +: 32] = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a handshake; returns at the negedge it was seen
  task automatic wait_accept(input string name, input logic [N-1:0] exp);
    logic [N-1:0] got;
    got = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        got = req_ready & req_valid;
        break;
      end
      next_cycle();
    end
    check(name, 32'(got), 32'(exp));
  endtask

  initial begin
    aresetn = 1'b0; req_valid = '1; req_lock = '0; req_op = '0; req_data = '0;
    defer_en = 1'b0; control_vblank = 1'b0;
    set_req(0, 8'd3,  32'h05FF_0000);
    set_req(1, 8'd13, 32'h0000_1111);
    set_req(2, 8'd15, 32'h0000_2222);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_op", 32'(control_op), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ops", 32'(ops_issued), 32'd0);
    next_cycle();
    aresetn = 1'b1;

    // Immediate op timing and round-robin with all three valid
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      case (k)
        0:  check("first_ready", 32'(req_ready), 32'b001);
        1:  begin
              check("imm_op", 32'(control_op), 32'd3);
              check("imm_data", control_data, 32'h05FF_0000);
              check("imm_ops", 32'(ops_issued), 32'd1);
            end
        4:  check("imm_op_last", 32'(control_op), 32'd3);
        5:  check("imm_gap0", 32'(control_op), 32'd0);
        6:  check("imm_gap1_data", control_data, 32'h05FF_0000);
        7:  check("rr_ready1", 32'(req_ready), 32'b010);
        8:  check("rr_op1", 32'(control_op), 32'd13);
        14: check("rr_ready2", 32'(req_ready), 32'b100);
        15: check("rr_op2", 32'(control_op), 32'd15);
        21: check("rr_ready0", 32'(req_ready), 32'b001);
        default: ;
      endcase
      next_cycle();
    end
    req_valid = '0;

    // Lock: move rr to 2, then req2 locks and keeps the grant once
    req_valid = 3'b010;
    wait_accept("lock_pre", 3'b010);
    next_cycle();
    req_valid = 3'b111;
    set_req(2, 8'd14, 32'h0000_00E0);
    req_lock  = 3'b100;
    wait_accept("lock_first", 3'b100);
    next_cycle();
    set_req(2, 8'd15, 32'h0000_00F0);
    req_lock  = 3'b000;
    wait_accept("lock_again", 3'b100);
    next_cycle();
    req_valid = 3'b011;
    wait_accept("lock_release", 3'b001);
    next_cycle();
    req_valid = '0;

    // Vblank deferral of a DIMENSIONS op
    defer_en = 1'b1;
    set_req(1, 8'd2, 32'h0240_02D0);
    req_valid = 3'b010;
    wait_accept("vbl_accept", 3'b010);
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("vbl_wait_busy", 32'(busy), 32'd1);
      check("vbl_wait_op", 32'(control_op), 32'd0);
      next_cycle();
    end
    control_vblank = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("vbl_op", 32'(control_op), (j >= 3 && j <= 6) ? 32'd2 : 32'd0);
      if (j == 3) check("vbl_data", control_data, 32'h0240_02D0);
      next_cycle();
    end
    control_vblank = 1'b0;
    defer_en = 1'b0;

    // Reset during the second HOLD cycle
    req_valid = 3'b001;
    wait_accept("mid_accept", 3'b001);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("mid_hold1", 32'(control_op), 32'd3);
    next_cycle();
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_hold2", 32'(control_op), 32'd3);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    next_cycle();
    aresetn = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    check("mid_after_op", 32'(control_op), 32'd0);
    check("mid_after_ops", 32'(ops_issued), 32'd0);
    check("mid_after_busy", 32'(busy), 32'd0);
    check("mid_after_rr", 32'(req_ready), 32'b001);
    next_cycle();
    req_valid = '0;
    repeat (10) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
